// File: rtl/cic_decim_comb.sv
// CIC decimator back end: rate counter, decimation capture and N comb stages.
// Comb arithmetic wraps modulo 2^WIDTH; output is the truncated top slice.
module cic_decim_comb #(
  parameter int WIDTH      = 64,
  parameter int STAGES     = 3,
  parameter int OUT_WIDTH  = 24,
  parameter int RATE_WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_strobe,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic        [RATE_WIDTH-1:0] rate,
  output logic                        out_strobe,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  logic [RATE_WIDTH-1:0] cnt;
  logic [RATE_WIDTH-1:0] r_lat;
  logic [STAGES:0]       v;
  logic [WIDTH-1:0]      x [STAGES+1];
  logic [WIDTH-1:0]      d [STAGES];
  logic                  last_cnt;
  logic                  boundary;

  // A latched ratio of 0 or 1 means every strobe closes a period.
  assign last_cnt =
    (r_lat <= RATE_WIDTH'(1)) ||
    (cnt == r_lat - RATE_WIDTH'(1));
  assign boundary = in_strobe && last_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt        <= '0;
      r_lat      <= rate;
      v          <= '0;
      out_strobe <= 1'b0;
      out_data   <= '0;
      for (int k = 0; k <= STAGES; k++)
        x[k] <= '0;
      for (int k = 0; k < STAGES; k++)
        d[k] <= '0;
    end else begin
      v[0] <= boundary;
      if (in_strobe) begin
        if (last_cnt) begin
          cnt   <= '0;
          r_lat <= rate;
          x[0]  <= in_data;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      for (int k = 1; k <= STAGES; k++) begin
        v[k] <= v[k-1];
        if (v[k-1]) begin
          x[k]   <= x[k-1] - d[k-1];
          d[k-1] <= x[k-1];
        end
      end
      out_strobe <= v[STAGES];
      if (v[STAGES])
        out_data <= x[STAGES][WIDTH-1 -: OUT_WIDTH];
    end
  end

endmodule

// File: tb/tb_cic_decim_comb.sv
// Bench for cic_decim_comb: three parameterisations share one stimulus,
// each checked against a scoreboard fed by a behavioural comb model.
module tb_cic_decim_comb;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_strobe;
  logic [7:0]  rate;
  logic [63:0] din;
  logic        sa, sc, sd;
  logic [15:0] oa;
  logic [7:0]  oc;
  logic [23:0] od;

  always #5 clock = ~clock;

  cic_decim_comb #(
    .WIDTH(16), .STAGES(1),
    .OUT_WIDTH(16), .RATE_WIDTH(8)
  ) dut_a (
    .clock(clock), .reset_n(reset_n),
    .in_strobe(in_strobe), .in_data(din[15:0]),
    .rate(rate), .out_strobe(sa), .out_data(oa)
  );

  cic_decim_comb #(
    .WIDTH(8), .STAGES(1),
    .OUT_WIDTH(8), .RATE_WIDTH(8)
  ) dut_c (
    .clock(clock), .reset_n(reset_n),
    .in_strobe(in_strobe), .in_data(din[7:0]),
    .rate(rate), .out_strobe(sc), .out_data(oc)
  );

  cic_decim_comb dut_d (
    .clock(clock), .reset_n(reset_n),
    .in_strobe(in_strobe), .in_data(din),
    .rate(rate), .out_strobe(sd), .out_data(od)
  );

  typedef struct {
    logic [63:0] val;
    int          due;
  } exp_t;

  typedef struct {
    logic [63:0] din;
    logic [63:0] exp_c;
  } vec_t;

  exp_t qa[$];
  exp_t qc[$];
  exp_t qd[$];

  int W[3]  = '{16, 8, 64};
  int N[3]  = '{1, 1, 3};
  int OW[3] = '{16, 8, 24};

  logic [63:0] dm [3][8];
  logic [63:0] last [3];
  int cnt_m, rlat_m;
  int cyc, n_chk, n_fail, n_sa, base;
  vec_t tbl[6];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(int i,
                                        logic [63:0] xin);
    logic [63:0] m, x, y;
    m = (W[i] == 64) ? '1 : ((64'd1 << W[i]) - 64'd1);
    x = xin & m;
    for (int k = 0; k < N[i]; k++) begin
      y = (x - dm[i][k]) & m;
      dm[i][k] = x;
      x = y;
    end
    return (x >> (W[i] - OW[i])) &
           ((64'd1 << OW[i]) - 64'd1);
  endfunction

  task automatic push(int i, logic [63:0] v, int due);
    exp_t e;
    e.val = v;
    e.due = due;
    case (i)
      0: qa.push_back(e);
      1: qc.push_back(e);
      default: qd.push_back(e);
    endcase
  endtask

  task automatic mon(int i, logic s, logic [63:0] dv);
    bit es;
    logic [63:0] ev;
    es = 1'b0;
    ev = '0;
    case (i)
      0: if (qa.size() > 0 && qa[0].due == cyc) begin
           es = 1'b1; ev = qa.pop_front().val;
         end
      1: if (qc.size() > 0 && qc[0].due == cyc) begin
           es = 1'b1; ev = qc.pop_front().val;
         end
      default:
         if (qd.size() > 0 && qd[0].due == cyc) begin
           es = 1'b1; ev = qd.pop_front().val;
         end
    endcase
    if (i == 0 && s) n_sa++;
    chk($sformatf("strobe[%0d]", i), {63'd0, s}, {63'd0, es});
    if (es) last[i] = ev;
    chk($sformatf("data[%0d]", i), dv, last[i]);
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
    mon(0, sa, {48'd0, oa});
    mon(1, sc, {56'd0, oc});
    mon(2, sd, {40'd0, od});
  endtask

  task automatic drive(bit rn, bit st, logic [7:0] r,
                       logic [63:0] dv, bit ov = 1'b0,
                       logic [63:0] ec = '0);
    logic [63:0] v;
    reset_n   = rn;
    in_strobe = st;
    rate      = r;
    din       = dv;
    if (!rn) begin
      cnt_m  = 0;
      rlat_m = int'(r);
      qa.delete(); qc.delete(); qd.delete();
      for (int i = 0; i < 3; i++) begin
        last[i] = '0;
        for (int k = 0; k < 8; k++) dm[i][k] = '0;
      end
    end else if (st) begin
      if (rlat_m <= 1 || cnt_m == rlat_m - 1) begin
        cnt_m  = 0;
        rlat_m = int'(r);
        for (int i = 0; i < 3; i++) begin
          v = model(i, dv);
          if (i == 1 && ov) v = ec;
          push(i, v, cyc + 2 + N[i]);
        end
      end else begin
        cnt_m++;
      end
    end
    tick();
  endtask

  task automatic idle(int n, logic [7:0] r);
    for (int j = 0; j < n; j++)
      drive(1'b1, 1'b0, r, 64'hDEAD_BEEF_5A5A_A5A5);
  endtask

  task automatic rst(int n, logic [7:0] r);
    for (int j = 0; j < n; j++)
      drive(1'b0, 1'b0, r, '0);
  endtask

  initial begin
    tbl[0] = '{64'h7F, 64'h7F};
    tbl[1] = '{64'h81, 64'h02};
    tbl[2] = '{64'h83, 64'h02};
    tbl[3] = '{64'h00, 64'h7D};
    tbl[4] = '{64'hFF, 64'hFF};
    tbl[5] = '{64'h01, 64'h02};

    cyc = 0; n_chk = 0; n_fail = 0; n_sa = 0;
    reset_n = 1'b0; in_strobe = 1'b0;
    rate = 8'd1; din = '0;
    cnt_m = 0; rlat_m = 1;

    rst(3, 8'd1);

    for (int j = 0; j < 10; j++)
      drive(1'b1, 1'b1, 8'd1, 64'h100);
    idle(6, 8'd1);

    rst(2, 8'd1);
    for (int j = 0; j < 6; j++)
      drive(1'b1, 1'b1, 8'd1, tbl[j].din,
            1'b1, tbl[j].exp_c);
    idle(5, 8'd1);

    rst(2, 8'd4);
    base = n_sa;
    for (int j = 1; j <= 16; j++)
      drive(1'b1, 1'b1, 8'd4, 64'(j));
    idle(4, 8'd4);
    chk("r025_count", 64'(n_sa - base), 64'd4);
    chk("r025_value", {48'd0, oa}, 64'd4);

    rst(2, 8'd4);
    base = n_sa;
    drive(1'b1, 1'b1, 8'd4, 64'd10);
    drive(1'b1, 1'b1, 8'd4, 64'd20);
    drive(1'b1, 1'b1, 8'd8, 64'd30);
    drive(1'b1, 1'b1, 8'd8, 64'd40);
    idle(4, 8'd8);
    chk("r028_first", 64'(n_sa - base), 64'd1);
    for (int j = 0; j < 7; j++)
      drive(1'b1, 1'b1, 8'd8, 64'(50 + j));
    idle(4, 8'd8);
    chk("r028_no_early", 64'(n_sa - base), 64'd1);
    drive(1'b1, 1'b1, 8'd8, 64'd99);
    idle(4, 8'd8);
    chk("r028_second", 64'(n_sa - base), 64'd2);

    rst(2, 8'd1);
    drive(1'b1, 1'b1, 8'd1, 64'h1234_5678_9ABC_DEF0);
    drive(1'b1, 1'b1, 8'd1, 64'h0FED_CBA9_8765_4321);
    base = n_sa;
    rst(1, 8'd2);
    idle(6, 8'd2);
    chk("r029_no_strobe", 64'(n_sa - base), 64'd0);
    chk("r029_out_a", {48'd0, oa}, 64'd0);
    chk("r029_out_d", {40'd0, od}, 64'd0);
    drive(1'b1, 1'b1, 8'd2, 64'd7);
    idle(4, 8'd2);
    chk("r029_cnt0", 64'(n_sa - base), 64'd0);
    drive(1'b1, 1'b1, 8'd2, 64'd11);
    idle(4, 8'd2);
    chk("r029_restart", 64'(n_sa - base), 64'd1);
    chk("r029_value", {48'd0, oa}, 64'd11);

    rst(2, 8'd0);
    base = n_sa;
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 1'b1, 8'd0, 64'(3 * j + 1));
      idle(j % 3, 8'd0);
    end
    idle(4, 8'd0);
    chk("r030_count", 64'(n_sa - base), 64'd6);

    rst(2, 8'd3);
    for (int j = 0; j < 400; j++)
      drive(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 3) != 0),
            8'($urandom_range(0, 5)),
            {$urandom(), $urandom()});
    idle(8, 8'd1);
    chk("drain_a", 64'(qa.size()), 64'd0);
    chk("drain_c", 64'(qc.size()), 64'd0);
    chk("drain_d", 64'(qd.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_decim_comb.md
CIC_DECIM_COMB -- requirements
Module: cic_decim_comb

Interface
REQ-001 SHALL have parameter WIDTH, default 64, integrator/comb datapath width in bits.
REQ-002 SHALL have parameter STAGES, default 3, number of comb stages N (1..8).
REQ-003 SHALL have parameter OUT_WIDTH, default 24, output sample width (≤ WIDTH).
REQ-004 SHALL have parameter RATE_WIDTH, default 8, width of decimation-rate input.
REQ-005 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port in_strobe  input  1  one-clock qualifier, in_data valid (integrator-rate strobe).
REQ-008 SHALL have port in_data  input  WIDTH signed  final-integrator output.
REQ-009 SHALL have port rate  input  RATE_WIDTH unsigned  decimation ratio R.
REQ-010 SHALL have port out_strobe  output  1  one-clock pulse, out_data new.
REQ-011 SHALL have port out_data  output  OUT_WIDTH signed  decimated, comb-filtered sample.

Function
REQ-012 SHALL keep a decimation counter cnt and a latched ratio r_lat; only in_strobe cycles advance cnt.
REQ-013 SHALL treat r_lat of 0 or 1 as decimation by 1 (every in_strobe produces a sample).
REQ-014 SHALL, on in_strobe with cnt == r_lat-1 (or r_lat ≤ 1): capture in_data into the stage-0 register, clear cnt, load r_lat from rate; otherwise on in_strobe: cnt+1.
REQ-015 SHALL apply rate changes only at that decimation boundary; a mid-period rate change does not alter the current period.
REQ-016 SHALL implement N pipelined comb stages, differential delay 1: on its valid, stage k computes y_k = x_k - d_k, sets d_k = x_k, passes valid to stage k+1 next clock.
REQ-017 SHALL perform all comb arithmetic in WIDTH bits, two's complement, modulo 2^WIDTH wrap with no saturation (required for CIC correctness with wrapping integrators).
REQ-018 SHALL form out_data as bits [WIDTH-1 : WIDTH-OUT_WIDTH] of the last comb result (truncation, no rounding).
REQ-019 SHALL assert out_strobe for exactly one clock, STAGES+1 clocks after the clock edge that sampled the boundary in_strobe; out_data holds until the next out_strobe.
REQ-020 SHALL be fully pipelined: back-to-back boundary strobes (R=1, in_strobe every clock) produce out_strobe every clock with no loss.
REQ-021 SHALL ignore in_data when in_strobe is low; comb state changes only on its stage valid.

Reset
REQ-022 SHALL, when reset_n is low at a rising edge, clear cnt, all comb data and delay registers, all stage valids, out_data and out_strobe to 0, and load r_lat from rate.
REQ-023 SHALL, on reset mid-operation, discard all in-flight samples (no out_strobe from pre-reset samples).
REQ-024 SHALL count the first post-reset in_strobe as count 0 of a new period.

Verification
REQ-025 N=1, WIDTH=16, OUT_WIDTH=16, R=4, in_data = 1,2,3,... on every in_strobe -> outputs 4,4,4,... except first = 4 (d reset 0, x=4), each out_strobe 2 clocks after the 4th/8th/... strobe.
REQ-026 Defaults, R=1, in_strobe every clock, in_data constant 0x100 -> first outputs per binomial start-up then steady 0, one out_strobe per clock, latency 4 clocks.
REQ-027 N=1, WIDTH=8, OUT_WIDTH=8, R=1, in_data 0x7F then 0x81 (wrapped ramp, step +2) -> out_data 0x7F then 0x02 (modulo wrap, no saturation).
REQ-028 R=4, rate changed to 8 after 2nd strobe of a period -> current period ends after 4 strobes, next after 8.
REQ-029 reset_n low for 1 clock while 2 samples in pipeline -> out_strobe stays 0, all outputs 0, next period restarts at cnt 0.
REQ-030 rate = 0 -> every in_strobe yields out_strobe, identical to rate = 1.
